// File: rtl/c17_bist_pkg.sv
// c17_bist_pkg: shared FSM state encoding and default MISR constants for the c17 BIST slice.
package c17_bist_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} c17_state_e;
  localparam logic [7:0] POLY_DEF = 8'h1D;
  localparam logic [7:0] SEED_DEF = 8'hFF;
endpackage

// File: rtl/c17_misr_step.sv
// misr_step: combinational MISR next-state, z1 into bit 0 and z2 into bit 1.
module misr_step #(
  parameter int SIG_W = 8,
  parameter logic [SIG_W-1:0] POLY = SIG_W'(8'h1D)
) (
  input  logic [SIG_W-1:0] sig_i,
  input  logic             z1_i,
  input  logic             z2_i,
  output logic [SIG_W-1:0] sig_o
);
  assign sig_o = {sig_i[SIG_W-2:0], 1'b0} ^ (sig_i[SIG_W-1] ? POLY : '0) ^ SIG_W'({z2_i, z1_i});
endmodule

// File: rtl/c17_misr.sv
// c17_misr: run-controlled MISR compacting c17 z1/z2 responses.
// Golden pass/fail verdict only when C17_MISR_GOLDEN_EN is defined.
module c17_misr
  import c17_bist_pkg::*;
#(
  parameter int SIG_W = 8,
  parameter int N_PAT = 32,
  parameter logic [SIG_W-1:0] POLY = SIG_W'(POLY_DEF),
  parameter logic [SIG_W-1:0] SEED = SIG_W'(SEED_DEF),
  parameter logic [SIG_W-1:0] GOLDEN = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       resp_valid,
  input  logic                       z1,
  input  logic                       z2,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(N_PAT+1)-1:0] pat_cnt,
  output logic [SIG_W-1:0]           signature,
  output logic                       pass,
  output logic                       fail
);
  localparam int CW = $clog2(N_PAT + 1);
  c17_state_e      state_q;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, last;
  misr_step #(.SIG_W(SIG_W), .POLY(POLY)) u_step (
    .sig_i(sig_q), .z1_i(z1), .z2_i(z2), .sig_o(sig_d)
  );
  assign last = cnt_q == CW'(N_PAT - 1);
`ifdef C17_MISR_GOLDEN_EN
  logic pass_q, fail_q;
  assign pass = pass_q;
  assign fail = fail_q;
`else
  logic unused_golden;
  assign unused_golden = ^GOLDEN;
  assign pass = 1'b0;
  assign fail = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef C17_MISR_GOLDEN_EN
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
`endif
    end else if (state_q != RUN) begin
      if (start) begin
        state_q <= RUN;
        sig_q   <= SEED;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
`ifdef C17_MISR_GOLDEN_EN
        pass_q  <= 1'b0;
        fail_q  <= 1'b0;
`endif
      end
    end else if (resp_valid) begin
      sig_q <= sig_d;
      cnt_q <= cnt_q + CW'(1);
      if (last) begin
        state_q <= DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
`ifdef C17_MISR_GOLDEN_EN
        pass_q  <= sig_d == GOLDEN;
        fail_q  <= sig_d != GOLDEN;
`endif
      end
    end
  end
  assign busy      = busy_q;
  assign done      = done_q;
  assign pat_cnt   = cnt_q;
  assign signature = sig_q;
endmodule

// File: tb/tb_c17_misr.sv
// tb_c17_misr: directed checks of c17_misr on three parameterisations sharing clk/rst.
module tb_c17_misr;
  logic clk = 1'b0, rst = 1'b1, z1 = 1'b0, z2 = 1'b0;
  logic start_a = 1'b0, rv_a = 1'b0, start_b = 1'b0, rv_b = 1'b0, start_c = 1'b0, rv_c = 1'b0;
  logic busy_a, done_a, pass_a, fail_a, busy_b, done_b, pass_b, fail_b, busy_c, done_c, pass_c, fail_c;
  logic [5:0] cnt_a;
  logic [1:0] cnt_b;
  logic [0:0] cnt_c;
  logic [7:0] sig_a, sig_b, sig_c;
  int n_chk = 0, n_pass = 0;
  bit gold;
  always #5 clk = ~clk;
  c17_misr dut_a (.clk(clk), .rst(rst), .start(start_a), .resp_valid(rv_a), .z1(z1), .z2(z2),
    .busy(busy_a), .done(done_a), .pat_cnt(cnt_a), .signature(sig_a), .pass(pass_a), .fail(fail_a));
  c17_misr #(.N_PAT(2), .SEED(8'h00), .GOLDEN(8'h07)) dut_b (.clk(clk), .rst(rst), .start(start_b),
    .resp_valid(rv_b), .z1(z1), .z2(z2), .busy(busy_b), .done(done_b), .pat_cnt(cnt_b),
    .signature(sig_b), .pass(pass_b), .fail(fail_b));
  c17_misr #(.N_PAT(1), .SEED(8'h00)) dut_c (.clk(clk), .rst(rst), .start(start_c), .resp_valid(rv_c),
    .z1(z1), .z2(z2), .busy(busy_c), .done(done_c), .pat_cnt(cnt_c), .signature(sig_c),
    .pass(pass_c), .fail(fail_c));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic cap_b(input logic a, input logic b);
    z1 = a; z2 = b; rv_b = 1'b1;
    tick();
    rv_b = 1'b0;
  endtask
  initial begin
`ifdef C17_MISR_GOLDEN_EN
    gold = 1'b1;
`else
    gold = 1'b0;
`endif
    start_a = 1'b1; rv_a = 1'b1; start_b = 1'b1; rv_b = 1'b1;
    tick(2);
    chk("rst_sig_a", sig_a, 8'hFF);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_sig_b", sig_b, 8'h00);
    chk("rst_pf_b", {pass_b, fail_b}, 0);
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; rv_b = 1'b0;
    tick();
    chk("idle_rv_cnt_a", cnt_a, 0);
    chk("idle_rv_sig_a", sig_a, 8'hFF);
    rv_a = 1'b0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("start_busy_a", busy_a, 1);
    z1 = 1'b0; z2 = 1'b0; rv_a = 1'b1;
    tick();
    chk("poly_sig_a", sig_a, 8'hE3);
    chk("poly_cnt_a", cnt_a, 1);
    z1 = 1'b1;
    tick();
    rv_a = 1'b0;
    chk("poly2_sig_a", sig_a, 8'hDA);
    chk("poly2_cnt_a", cnt_a, 2);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("run_busy_b", busy_b, 1);
    cap_b(1, 1);
    chk("full1_sig_b", sig_b, 8'h03);
    chk("full1_cnt_b", cnt_b, 1);
    chk("full1_pf_b", {pass_b, fail_b}, 0);
    cap_b(1, 0);
    chk("full2_sig_b", sig_b, 8'h07);
    chk("full2_done_b", {busy_b, done_b}, 2'b01);
    chk("full2_pf_b", {pass_b, fail_b}, gold ? 2'b10 : 2'b00);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("restart_sig_b", sig_b, 8'h00);
    chk("restart_cnt_b", cnt_b, 0);
    chk("restart_pf_b", {pass_b, fail_b}, 0);
    cap_b(1, 1);
    tick();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    chk("stall_sig_b", sig_b, 8'h03);
    chk("stall_cnt_b", {busy_b, cnt_b}, 3'b101);
    cap_b(1, 0);
    chk("stall_done_sig_b", sig_b, 8'h07);
    rv_b = 1'b1; z1 = 1'b1; z2 = 1'b1;
    tick(2);
    rv_b = 1'b0;
    chk("done_hold_sig_b", sig_b, 8'h07);
    chk("done_hold_cnt_b", cnt_b, 2);
    chk("done_hold_st_b", {busy_b, done_b}, 2'b01);
    start_b = 1'b1; rv_b = 1'b1;
    tick();
    start_b = 1'b0; rv_b = 1'b0;
    chk("discard_sig_b", sig_b, 8'h00);
    chk("discard_cnt_b", {busy_b, cnt_b}, 3'b100);
    cap_b(1, 1);
    cap_b(0, 0);
    chk("bad_sig_b", sig_b, 8'h06);
    chk("bad_pf_b", {pass_b, fail_b}, gold ? 2'b01 : 2'b00);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    cap_b(1, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_sig_b", sig_b, 8'h00);
    chk("abort_st_b", {busy_b, done_b, cnt_b}, 0);
    chk("abort_pf_b", {pass_b, fail_b}, 0);
    chk("abort_busy_a", busy_a, 0);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    cap_b(1, 1);
    cap_b(1, 0);
    chk("rerun_sig_b", sig_b, 8'h07);
    chk("rerun_done_b", {busy_b, done_b, cnt_b}, 4'b0110);
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    z1 = 1'b1; z2 = 1'b0; rv_c = 1'b1;
    tick();
    chk("one_sig_c", sig_c, 8'h01);
    chk("one_st_c", {busy_c, done_c, cnt_c}, 3'b011);
    tick();
    rv_c = 1'b0;
    chk("one_hold_c", {sig_c, cnt_c}, {8'h01, 1'b1});
    chk("one_pf_c", {pass_c, fail_c, pass_a, fail_a}, gold ? 4'b0100 : 4'b0000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/c17_misr.md
C17_MISR -- requirements
Module: c17_misr

Interface
REQ-001 The block SHALL have parameter SIG_W, default 8, the signature register width (minimum 2).
REQ-002 The block SHALL have parameter N_PAT, default 32, the number of responses compacted per run (minimum 1).
REQ-003 The block SHALL have parameter POLY, default 8'h1D, the feedback taps (x^8+x^4+x^3+x^2+1).
REQ-004 The block SHALL have parameter SEED, default 8'hFF, the initial signature loaded at reset and at run start.
REQ-005 The block SHALL have parameter GOLDEN, default 8'h00, the expected fault-free signature.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port start, input, 1 bit: begin a compaction run.
REQ-009 The block SHALL have port resp_valid, input, 1 bit: the z1/z2 pair is valid this cycle.
REQ-010 The block SHALL have ports z1 and z2, inputs, 1 bit each: c17 circuit outputs under test.
REQ-011 The block SHALL have port busy, output, 1 bit: asserted while in RUN.
REQ-012 The block SHALL have port done, output, 1 bit: asserted while in DONE.
REQ-013 The block SHALL have port pat_cnt, output, $clog2(N_PAT+1) bits: the number of responses captured in the current run.
REQ-014 The block SHALL have port signature, output, SIG_W bits: the current MISR contents.
REQ-015 The block SHALL have ports pass and fail, outputs, 1 bit each: the golden-comparison verdict.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE; busy = (state==RUN) and done = (state==DONE), both registered.
REQ-017 In IDLE or DONE, start=1 SHALL load signature<=SEED and pat_cnt<=0, clear pass/fail, and move to RUN.
REQ-018 In RUN, start SHALL be ignored.
REQ-019 In RUN with resp_valid=1, the block SHALL apply the update sig_next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ {0..., z2, z1}, with z1 XORed into bit 0 and z2 into bit 1.
REQ-020 On each such update, pat_cnt SHALL increment by 1.
REQ-021 Capture latency SHALL be one cycle: signature and pat_cnt reflect a capture on the following edge.
REQ-022 In RUN with resp_valid=0, signature and pat_cnt SHALL hold.
REQ-023 A capture that brings pat_cnt to N_PAT SHALL move the FSM to DONE on the same edge, with that final capture included.
REQ-024 In DONE, signature, pat_cnt, pass and fail SHALL hold until start or rst.
REQ-025 resp_valid SHALL be ignored in IDLE and DONE; no update occurs and pat_cnt never exceeds N_PAT.
REQ-026 start and resp_valid both high in DONE SHALL restart the run and discard the response.
REQ-027 When N_PAT=1, a single capture SHALL move the FSM from RUN to DONE.

Reset
REQ-028 rst=1 SHALL force on the next edge: state=IDLE, signature=SEED, pat_cnt=0, busy=0, done=0, pass=0, fail=0.
REQ-029 rst SHALL take priority over start and resp_valid, and SHALL abort a run in progress with no partial verdict.

Configuration
REQ-030 With macro C17_MISR_GOLDEN_EN defined, pass and fail SHALL be registered on the edge entering DONE: pass = (sig_next==GOLDEN) and fail = ~pass.
REQ-031 With C17_MISR_GOLDEN_EN defined, pass and fail SHALL both be 0 outside DONE.
REQ-032 Without C17_MISR_GOLDEN_EN, pass and fail SHALL be tied to 0, the GOLDEN parameter is unused, and no comparator is synthesised.

Structure
REQ-033 The FSM state enum (IDLE/RUN/DONE) and the default POLY/SEED constants SHALL live in the shared package c17_bist_pkg.
REQ-034 The MISR update SHALL be a sub-module misr_step (combinational next-state function) instantiated once; the FSM and counter remain in c17_misr.

Verification
REQ-035 Reset scenario: SEED=8'hFF, rst for 2 cycles, then start and resp_valid held high -> signature=8'hFF, pat_cnt=0, busy=0, done=0 while rst=1.
REQ-036 Polynomial scenario: SEED=8'hFF, start, one capture with z1=0, z2=0 -> signature=8'hE3, pat_cnt=1.
REQ-037 Full-run scenario: SEED=8'h00, N_PAT=2, captures (z1,z2)=(1,1) then (1,0) -> signature 8'h03 then 8'h07; done=1 and busy=0 on the edge of the second capture.
REQ-038 Stall/ignore scenario: the full-run scenario with resp_valid gaps of 3 cycles plus a start pulse mid-RUN and resp_valid pulses in DONE -> same 8'h07 signature, pat_cnt=2, no restart.
REQ-039 Golden scenario (macro on): GOLDEN=8'h07 with the full-run scenario -> pass=1, fail=0; rerun with second pair (0,0) -> signature 8'h06, pass=0, fail=1. Macro off: pass=fail=0 throughout.
REQ-040 Abort scenario: rst asserted after one capture in RUN -> IDLE, signature=SEED, pat_cnt=0; a fresh start then completes normally.
